// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime-configurable framing and a show-ahead RX FIFO.
// Framing, parity and overflow errors are reported through sticky flags.
module uart_rx_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              rx_i,
  input  logic [31:0]                       cfg_divider_i,
  input  logic [1:0]                        cfg_stop_i,
  input  logic [1:0]                        cfg_parity_i,
  input  logic                              rd_req_i,
  output logic [DATA_W-1:0]                 rd_data_o,
  output logic                              rd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count_o,
  output logic                              busy_o,
  output logic                              frame_err_o,
  output logic                              parity_err_o,
  output logic                              overflow_o,
  input  logic                              err_clr_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_W);
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;

  logic [DW-1:0]     div_q;
  logic [DW-1:0]     cnt_q;
  logic              stop2_q;
  logic              par_en_q;
  logic              par_odd_q;
  logic [BW-1:0]     bit_idx_q;
  logic              stop_idx_q;
  logic              stop_bad_q;
  logic              par_bad_q;
  logic [DATA_W-1:0] shreg_q;
  logic              push_q;

  logic              mid_bit;
  logic              start_det;
  logic              shift_en;
  logic              par_smp;
  logic              stop_smp;
  logic              commit;
  logic              frame_evt;
  logic              parity_evt;
  logic              par_exp;
  logic [DW-1:0]     div_eff;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     rd_ptr_d;
  logic [CW-1:0]     count_d;
  logic              pop;
  logic              full;
  logic              wr_en;
  logic              ovf_evt;
  logic [DATA_W-1:0] head_d;

  // rx_i synchroniser; idles high so a reset never fakes a start edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign div_eff = (cfg_divider_i < DW'(2)) ? DW'(2) : cfg_divider_i;
  assign mid_bit = (cnt_q == (div_q >> 1));
  assign par_exp = (^shreg_q) ^ par_odd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle sample strobes
  always_comb begin
    state_d    = state_q;
    start_det  = 1'b0;
    shift_en   = 1'b0;
    par_smp    = 1'b0;
    stop_smp   = 1'b0;
    commit     = 1'b0;
    frame_evt  = 1'b0;
    parity_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          start_det = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (mid_bit) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (mid_bit) begin
          shift_en = 1'b1;
          if (bit_idx_q == BW'(DATA_W - 1)) state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (mid_bit) begin
          par_smp    = 1'b1;
          parity_evt = (rx_s != par_exp);
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (mid_bit) begin
          stop_smp = 1'b1;
          if (!stop2_q || stop_idx_q) begin
            if (stop_bad_q || !rx_s) begin
              frame_evt = 1'b1;
              state_d   = S_BREAK;
            end else begin
              commit  = !par_bad_q;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame datapath: latched config, bit timer, shifter and error tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q      <= DW'(2);
      cnt_q      <= '0;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      stop_bad_q <= 1'b0;
      par_bad_q  <= 1'b0;
      shreg_q    <= '0;
      push_q     <= 1'b0;
    end else begin
      push_q <= commit;
      if (start_det) begin
        div_q      <= div_eff;
        stop2_q    <= (cfg_stop_i == 2'b01);
        par_en_q   <= (cfg_parity_i == 2'b01) || (cfg_parity_i == 2'b10);
        par_odd_q  <= (cfg_parity_i == 2'b10);
        cnt_q      <= '0;
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
        stop_bad_q <= 1'b0;
        par_bad_q  <= 1'b0;
      end else if (state_q != S_IDLE && state_q != S_BREAK) begin
        cnt_q <= (cnt_q == div_q - DW'(1)) ? '0 : cnt_q + DW'(1);
      end
      if (shift_en) begin
        shreg_q   <= {rx_s, shreg_q[DATA_W-1:1]};
        bit_idx_q <= bit_idx_q + BW'(1);
      end
      if (par_smp)  par_bad_q <= parity_evt;
      if (stop_smp) begin
        stop_idx_q <= 1'b1;
        stop_bad_q <= stop_bad_q | !rx_s;
      end
    end
  end

  // Registered status: busy mirrors the next state so it tracks state_q exactly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o       <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      busy_o       <= (state_d != S_IDLE);
      frame_err_o  <= frame_evt  | (frame_err_o  & ~err_clr_i);
      parity_err_o <= parity_evt | (parity_err_o & ~err_clr_i);
      overflow_o   <= ovf_evt    | (overflow_o   & ~err_clr_i);
    end
  end

  // FIFO control; a pop frees the slot so a push into a full FIFO still lands
  assign pop      = rd_req_i && rd_valid_o;
  assign full     = (fifo_count_o == CW'(FIFO_DEPTH));
  assign wr_en    = push_q && (!full || pop);
  assign ovf_evt  = push_q && full && !pop;
  assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign count_d  = fifo_count_o + CW'(wr_en) - CW'(pop);
  assign head_d   = (wr_en && (wr_ptr_q == rd_ptr_d)) ? shreg_q : mem[rd_ptr_d];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= shreg_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_o <= '0;
      rd_valid_o   <= 1'b0;
      rd_data_o    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_o <= count_d;
      rd_valid_o   <= (count_d != '0);
      rd_data_o    <= (count_d != '0) ? head_d : '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: framing options, error flags, FIFO
// fill/overflow, simultaneous push/pop while full, glitch and reset.
module tb_uart_rx_fifo;

  localparam int unsigned DIV = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx_i;
  logic [31:0] cfg_divider_i;
  logic [1:0]  cfg_stop_i;
  logic [1:0]  cfg_parity_i;
  logic        rd_req_i;
  logic        err_clr_i;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;
  logic [4:0]  fifo_count_o;
  logic        busy_o;
  logic        frame_err_o;
  logic        parity_err_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  uart_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .cfg_divider_i(cfg_divider_i),
    .cfg_stop_i   (cfg_stop_i),
    .cfg_parity_i (cfg_parity_i),
    .rd_req_i     (rd_req_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .fifo_count_o (fifo_count_o),
    .busy_o       (busy_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overflow_o   (overflow_o),
    .err_clr_i    (err_clr_i)
  );

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (DIV) @(negedge clk_i);
  endtask

  // Start bit, 8 data bits LSB first, optional parity, stop bits; last stop optionally low
  task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit,
                            input int nstop, input bit last_low);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    for (int s = 0; s < nstop; s++) drive_bit(!(last_low && s == nstop - 1));
    if (!last_low) rx_i = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic pop(output logic [7:0] d);
    d = rd_data_o;
    rd_req_i = 1'b1;
    @(negedge clk_i);
    rd_req_i = 1'b0;
  endtask

  task automatic clear_flags();
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rd_valid_o); end
    checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rd_data_o); end
    checks++; if (fifo_count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count_o); end
    checks++; if ({busy_o, frame_err_o, parity_err_o, overflow_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_status got %b exp 0000", {busy_o, frame_err_o, parity_err_o, overflow_o}); end
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_8n1();
    logic [7:0] d;
    send_frame(8'hA5, 0, 0, 1, 0);
    checks++; if (rd_data_o !== 8'hA5) begin errors++; $display("FAIL 8n1_data got %h exp a5", rd_data_o); end
    checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL 8n1_valid got %b exp 1", rd_valid_o); end
    checks++; if (fifo_count_o !== 5'd1) begin errors++; $display("FAIL 8n1_count got %0d exp 1", fifo_count_o); end
    checks++; if ({busy_o, frame_err_o, parity_err_o, overflow_o} !== 4'b0000) begin
      errors++; $display("FAIL 8n1_status got %b exp 0000", {busy_o, frame_err_o, parity_err_o, overflow_o}); end
    pop(d);
    checks++; if (rd_valid_o !== 1'b0 || fifo_count_o !== 5'd0) begin
      errors++; $display("FAIL 8n1_pop got valid %b count %0d exp 0 0", rd_valid_o, fifo_count_o); end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    cfg_parity_i = 2'b01;
    send_frame(8'h03, 1, 1, 1, 0);
    checks++; if (parity_err_o !== 1'b1) begin errors++; $display("FAIL parity_err got %b exp 1", parity_err_o); end
    checks++; if (fifo_count_o !== 5'd0) begin errors++; $display("FAIL parity_discard got %0d exp 0", fifo_count_o); end
    clear_flags();
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL parity_clr got %b exp 0", parity_err_o); end
    cfg_parity_i = 2'b10;
    send_frame(8'h03, 1, 1, 1, 0);
    checks++; if (fifo_count_o !== 5'd1 || rd_data_o !== 8'h03) begin
      errors++; $display("FAIL parity_odd_ok got count %0d data %h exp 1 03", fifo_count_o, rd_data_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL parity_odd_flag got %b exp 0", parity_err_o); end
    pop(d);
    cfg_parity_i = 2'b00;
  endtask

  task automatic test_frame_break();
    logic [7:0] d;
    cfg_stop_i = 2'b01;
    send_frame(8'h3C, 0, 0, 2, 1);
    checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL frame_err got %b exp 1", frame_err_o); end
    checks++; if (fifo_count_o !== 5'd0) begin errors++; $display("FAIL frame_discard got %0d exp 0", fifo_count_o); end
    repeat (40 * DIV) @(negedge clk_i);
    checks++; if (busy_o !== 1'b1 || fifo_count_o !== 5'd0) begin
      errors++; $display("FAIL break_hold got busy %b count %0d exp 1 0", busy_o, fifo_count_o); end
    rx_i = 1'b1;
    repeat (2 * DIV) @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || fifo_count_o !== 5'd0) begin
      errors++; $display("FAIL break_exit got busy %b count %0d exp 0 0", busy_o, fifo_count_o); end
    clear_flags();
    send_frame(8'h66, 0, 0, 2, 0);
    checks++; if (fifo_count_o !== 5'd1 || rd_data_o !== 8'h66 || frame_err_o !== 1'b0) begin
      errors++; $display("FAIL 8n2_ok got count %0d data %h ferr %b exp 1 66 0", fifo_count_o, rd_data_o, frame_err_o); end
    pop(d);
    cfg_stop_i = 2'b00;
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 0, 0, 1, 0);
    checks++; if (fifo_count_o !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", fifo_count_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow_o); end
    checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL ovf_head got %h exp 00", rd_data_o); end
    d = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      pop(d);
      checks++; if (d !== 8'(i)) begin errors++; $display("FAIL ovf_pop%0d got %h exp %h", i, d, 8'(i)); end
    end
    checks++; if (d !== 8'h0F || fifo_count_o !== 5'd0) begin
      errors++; $display("FAIL ovf_last got %h count %0d exp 0f 0", d, fifo_count_o); end
    clear_flags();
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] w;
    bit found;
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 0, 0, 1, 0);
    checks++; if (fifo_count_o !== 5'd16 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL b2b_full got count %0d ovf %b exp 16 0", fifo_count_o, overflow_o); end
    w = 8'h77;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(w[i]);
    rx_i = 1'b1;
    found = 0;
    for (int k = 0; k < 2 * DIV && !found; k++) begin
      if (!busy_o) begin
        rd_req_i = 1'b1;
        @(negedge clk_i);
        rd_req_i = 1'b0;
        found = 1;
      end else begin
        @(negedge clk_i);
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL b2b_timeout got busy %b exp 0", busy_o); end
    checks++; if (fifo_count_o !== 5'd16 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL b2b_pushpop got count %0d ovf %b exp 16 0", fifo_count_o, overflow_o); end
    checks++; if (rd_data_o !== 8'h21) begin errors++; $display("FAIL b2b_head got %h exp 21", rd_data_o); end
    repeat (DIV) @(negedge clk_i);
    d = 8'h00;
    for (int i = 0; i < 16; i++) pop(d);
    checks++; if (d !== 8'h77 || fifo_count_o !== 5'd0) begin
      errors++; $display("FAIL b2b_last got %h count %0d exp 77 0", d, fifo_count_o); end
  endtask

  task automatic test_glitch_reset();
    rx_i = 1'b0;
    repeat (DIV / 4) @(negedge clk_i);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_start got %b exp 1", busy_o); end
    rx_i = 1'b1;
    repeat (2 * DIV) @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || fifo_count_o !== 5'd0 || frame_err_o !== 1'b0) begin
      errors++; $display("FAIL glitch_idle got busy %b count %0d ferr %b exp 0 0 0", busy_o, fifo_count_o, frame_err_o); end
    send_frame(8'h11, 0, 0, 1, 0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    checks++; if (busy_o !== 1'b1 || fifo_count_o !== 5'd1) begin
      errors++; $display("FAIL rst_pre got busy %b count %0d exp 1 1", busy_o, fifo_count_o); end
    rst_i = 1'b1;
    rx_i  = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++; if ({rd_data_o, rd_valid_o, fifo_count_o, busy_o, frame_err_o, parity_err_o, overflow_o} !== 18'd0) begin
      errors++; $display("FAIL rst_mid got data %h valid %b count %0d busy %b exp all 0", rd_data_o, rd_valid_o, fifo_count_o, busy_o); end
    rst_i = 1'b0;
    repeat (DIV) @(negedge clk_i);
    send_frame(8'h5A, 0, 0, 1, 0);
    checks++; if (rd_data_o !== 8'h5A || fifo_count_o !== 5'd1) begin
      errors++; $display("FAIL rst_after got data %h count %0d exp 5a 1", rd_data_o, fifo_count_o); end
  endtask

  initial begin
    rst_i         = 1'b1;
    rx_i          = 1'b1;
    rd_req_i      = 1'b0;
    err_clr_i     = 1'b0;
    cfg_divider_i = 32'(DIV);
    cfg_stop_i    = 2'b00;
    cfg_parity_i  = 2'b00;
    test_reset();
    test_8n1();
    test_parity();
    test_frame_break();
    test_overflow();
    test_back_to_back();
    test_glitch_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
